// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller: FSM state and the
// bundle of pipeline-register enable/flush controls.
package pipe_ctrl_pkg;

    localparam int unsigned REG_AW_DEF = 5;

    typedef enum logic {RUN, MDU_WAIT} ctrl_state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exmem_en;
        logic exmem_flush;
        logic memwb_en;
    } ctrl_bus_t;

    localparam ctrl_bus_t CTRL_RUN = '{
        pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0, idex_en: 1'b1,
        idex_flush: 1'b0, exmem_en: 1'b1, exmem_flush: 1'b0, memwb_en: 1'b1
    };

    // Front end frozen, EX/MEM fed bubbles, older instruction drains through WB.
    localparam ctrl_bus_t CTRL_MDU_HOLD = '{
        pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_en: 1'b0,
        idex_flush: 1'b0, exmem_en: 1'b1, exmem_flush: 1'b1, memwb_en: 1'b1
    };

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detection between the ID and EX stages.
module load_use_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] i_id_rs1,
    input  logic [REG_AW-1:0] i_id_rs2,
    input  logic              i_id_use_rs1,
    input  logic              i_id_use_rs2,
    input  logic [REG_AW-1:0] i_ex_rd,
    input  logic              i_ex_mem_read,
    output logic              o_lu
);

    logic w_hit_rs1;
    logic w_hit_rs2;

    assign w_hit_rs1 = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
    assign w_hit_rs2 = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);

    // x0 is hard-wired to zero, so a load targeting it never creates a dependency.
    assign o_lu = i_ex_mem_read && (i_ex_rd != '0) && (w_hit_rs1 || w_hit_rs2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: load-use stalls, branch squash, MDU freeze with
// timeout, and a saturating stall-cycle counter.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW      = REG_AW_DEF,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MDU_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_br_taken,
    input  logic              ex_mdu_start,
    input  logic              mdu_done,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_en,
    output logic              idex_flush,
    output logic              exmem_en,
    output logic              exmem_flush,
    output logic              memwb_en,
    output logic              mdu_err,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int unsigned WCNT_W = (MDU_TIMEOUT > 2) ? $clog2(MDU_TIMEOUT) : 1;
    // The start cycle is the first stalled cycle, so the last wait cycle has index TIMEOUT-2.
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MDU_TIMEOUT - 2);

    ctrl_state_t       r_state;
    ctrl_state_t       w_state_nxt;
    logic [WCNT_W-1:0] r_wait_cnt;
    logic [WCNT_W-1:0] w_wait_cnt_nxt;
    logic [CNT_W-1:0]  r_stall_cnt;
    ctrl_bus_t         w_bus;
    logic              w_lu;
    logic              w_timeout;

    load_use_detect #(
        .REG_AW(REG_AW)
    ) u_load_use_detect (
        .i_id_rs1      (id_rs1),
        .i_id_rs2      (id_rs2),
        .i_id_use_rs1  (id_use_rs1),
        .i_id_use_rs2  (id_use_rs2),
        .i_ex_rd       (ex_rd),
        .i_ex_mem_read (ex_mem_read),
        .o_lu          (w_lu)
    );

    always_comb begin
        w_bus          = CTRL_RUN;
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_timeout      = 1'b0;
        case (r_state)
            RUN: begin
                if (ex_mdu_start) begin
                    w_bus          = CTRL_MDU_HOLD;
                    w_state_nxt    = MDU_WAIT;
                    w_wait_cnt_nxt = '0;
                end else if (ex_br_taken) begin
                    w_bus.ifid_flush = 1'b1;
                    w_bus.idex_flush = 1'b1;
                end else if (w_lu) begin
                    w_bus.pc_en      = 1'b0;
                    w_bus.ifid_en    = 1'b0;
                    w_bus.idex_flush = 1'b1;
                end
            end
            MDU_WAIT: begin
                if (mdu_done) begin
                    w_state_nxt = RUN;
                end else begin
                    w_bus = CTRL_MDU_HOLD;
                    if (r_wait_cnt == WAIT_LAST) begin
                        w_timeout        = 1'b1;
                        w_bus.idex_flush = 1'b1;
                        w_state_nxt      = RUN;
                    end else begin
                        w_wait_cnt_nxt = r_wait_cnt + WCNT_W'(1);
                    end
                end
            end
            default: w_state_nxt = RUN;
        endcase
        if (rst) begin
            w_bus     = '0;
            w_timeout = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RUN;
            r_wait_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (!w_bus.pc_en && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign pc_en       = w_bus.pc_en;
    assign ifid_en     = w_bus.ifid_en;
    assign ifid_flush  = w_bus.ifid_flush;
    assign idex_en     = w_bus.idex_en;
    assign idex_flush  = w_bus.idex_flush;
    assign exmem_en    = w_bus.exmem_en;
    assign exmem_flush = w_bus.exmem_flush;
    assign memwb_en    = w_bus.memwb_en;
    assign mdu_err     = w_timeout;
    assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios then random
// stimulus, compared cycle by cycle against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 6;
    localparam int TMO    = 8;
    localparam int SAT    = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [REG_AW-1:0] id_rs1, id_rs2, ex_rd;
    logic              id_use_rs1, id_use_rs2, ex_mem_read, ex_br_taken, ex_mdu_start, mdu_done;
    logic              pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic              exmem_en, exmem_flush, memwb_en, mdu_err;
    logic [CNT_W-1:0]  stall_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .REG_AW      (REG_AW),
        .CNT_W       (CNT_W),
        .MDU_TIMEOUT (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .ex_rd        (ex_rd),
        .ex_mem_read  (ex_mem_read),
        .ex_br_taken  (ex_br_taken),
        .ex_mdu_start (ex_mdu_start),
        .mdu_done     (mdu_done),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .ifid_flush   (ifid_flush),
        .idex_en      (idex_en),
        .idex_flush   (idex_flush),
        .exmem_en     (exmem_en),
        .exmem_flush  (exmem_flush),
        .memwb_en     (memwb_en),
        .mdu_err      (mdu_err),
        .stall_cnt    (stall_cnt)
    );

    always @(posedge clk) begin
        if (!rst) assert (!(ex_mdu_start && ex_br_taken)) else $error("illegal start+branch stimulus");
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Model: busy flag, count of wait cycles already spent, total stalled cycles.
    bit m_busy   = 1'b0;
    int m_waited = 0;
    int m_stalls = 0;

    // Returns {pc,ifid_en,ifid_fl,idex_en,idex_fl,exmem_en,exmem_fl,memwb, err}.
    function automatic logic [8:0] model_out();
        logic lu;
        lu = ex_mem_read && (ex_rd != 0) &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        if (rst) return '0;
        if (!m_busy) begin
            if (ex_mdu_start) return 9'b0000_0111_0;
            if (ex_br_taken)  return 9'b1111_1101_0;
            if (lu)           return 9'b0001_1101_0;
            return 9'b1101_0101_0;
        end
        if (mdu_done) return 9'b1101_0101_0;
        // Stalled-cycle number counting the start cycle as the first.
        if (m_waited + 2 == TMO) return 9'b0000_1111_1;
        return 9'b0000_0111_0;
    endfunction

    task automatic model_advance(input logic exp_pc_en);
        if (!exp_pc_en) m_stalls = (m_stalls == SAT) ? SAT : m_stalls + 1;
        if (m_busy) begin
            if (mdu_done || (m_waited + 2 == TMO)) m_busy = 1'b0;
            else m_waited++;
        end else if (ex_mdu_start) begin
            m_busy   = 1'b1;
            m_waited = 0;
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step(input string tag);
        logic [8:0] e;
        logic [7:0] got;
        #2;
        if (rst) begin
            m_busy   = 1'b0;
            m_waited = 0;
            m_stalls = 0;
        end
        e   = model_out();
        got = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en};
        check_eq({tag, ".bus"}, 32'(got), 32'(e[8:1]));
        check_eq({tag, ".err"}, 32'(mdu_err), 32'(e[0]));
        check_eq({tag, ".cnt"}, 32'(stall_cnt), 32'(m_stalls));
        @(posedge clk);
        if (!rst) model_advance(e[8]);
        @(negedge clk);
    endtask

    task automatic drv(input int rs1, input int rs2, input bit u1, input bit u2, input int rd,
                       input bit mr, input bit br, input bit st, input bit dn);
        id_rs1       = REG_AW'(rs1);
        id_rs2       = REG_AW'(rs2);
        id_use_rs1   = u1;
        id_use_rs2   = u2;
        ex_rd        = REG_AW'(rd);
        ex_mem_read  = mr;
        ex_br_taken  = br;
        ex_mdu_start = st;
        mdu_done     = dn;
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
            step(tag);
        end
    endtask

    initial begin
        rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        step("reset");
        rst = 1'b0;
        idle("idle", 1);

        drv(5, 0, 1, 0, 5, 1, 0, 0, 0); step("lu_rs1");
        idle("lu_after", 1);
        check_eq("lu_cnt_one", 32'(stall_cnt), 32'd1);
        drv(0, 3, 0, 1, 3, 1, 0, 0, 0); step("lu_rs2");

        drv(0, 0, 1, 1, 0, 1, 0, 0, 0); step("x0");
        drv(0, 7, 0, 0, 7, 1, 0, 0, 0); step("unused_rs2");
        drv(5, 0, 1, 0, 5, 1, 1, 0, 0); step("br_over_lu");
        drv(5, 0, 1, 0, 5, 0, 0, 0, 0); step("no_load");
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1); step("done_in_run");

        drv(0, 0, 0, 0, 0, 0, 0, 1, 0); step("mdu_start");
        idle("mdu_wait", 3);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1); step("mdu_done");
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0); step("mdu_reenter");
        drv(5, 0, 1, 0, 5, 1, 0, 0, 1); step("mdu_done_lu");
        check_eq("mdu_cnt", 32'(stall_cnt), 32'd7);

        drv(0, 0, 0, 0, 0, 0, 0, 1, 0); step("tmo_start");
        idle("tmo_wait", TMO - 1);
        idle("tmo_run", 1);

        drv(0, 0, 0, 0, 0, 0, 0, 1, 0); step("rst_start");
        idle("rst_wait", 2);
        rst = 1'b1;
        step("rst_mid_mdu");
        check_eq("rst_cnt_zero", 32'(stall_cnt), 32'd0);
        rst = 1'b0;
        idle("rst_release", 2);

        for (int i = 0; i < 1500; i++) begin
            bit st;
            st = ($urandom_range(0, 9) == 0);
            drv($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
                $urandom_range(0, 3), 1'($urandom),
                st ? 1'b0 : ($urandom_range(0, 7) == 0), st,
                ($urandom_range(0, 5) == 0));
            rst = ($urandom_range(0, 499) == 0);
            step("rnd");
            rst = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
